// File: rtl/calc1_top.sv
// calc1_top: four independent two-operand calculator ports.
// Each port takes a command, operand1 and tag in one cycle, operand2 in the
// next, and presents a one-cycle registered response on the edge after that.
// A port can accept a new command on the same edge it registers a response,
// so each port sustains one command every two cycles.
module calc1_top (
    input  logic        c_clk,
    input  logic [6:0]  reset,

    input  logic [3:0]  req1_cmd_in,
    input  logic [31:0] req1_data_in,
    input  logic [1:0]  req1_tag_in,
    input  logic [3:0]  req2_cmd_in,
    input  logic [31:0] req2_data_in,
    input  logic [1:0]  req2_tag_in,
    input  logic [3:0]  req3_cmd_in,
    input  logic [31:0] req3_data_in,
    input  logic [1:0]  req3_tag_in,
    input  logic [3:0]  req4_cmd_in,
    input  logic [31:0] req4_data_in,
    input  logic [1:0]  req4_tag_in,

    output logic [1:0]  out_resp1,
    output logic [31:0] out_data1,
    output logic [1:0]  out_tag1,
    output logic [1:0]  out_resp2,
    output logic [31:0] out_data2,
    output logic [1:0]  out_tag2,
    output logic [1:0]  out_resp3,
    output logic [31:0] out_data3,
    output logic [1:0]  out_tag3,
    output logic [1:0]  out_resp4,
    output logic [31:0] out_data4,
    output logic [1:0]  out_tag4
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // waiting for a command edge
        ST_OPND = 2'd1,   // command captured, operand2 arrives on next edge
        ST_EXEC = 2'd2    // both operands held, response registers this edge
    } state_t;

    localparam logic [3:0] CMD_NOP = 4'd0;
    localparam logic [3:0] CMD_ADD = 4'd1;
    localparam logic [3:0] CMD_SUB = 4'd2;
    localparam logic [3:0] CMD_SHL = 4'd5;
    localparam logic [3:0] CMD_SHR = 4'd6;

    localparam logic [1:0] RESP_NONE = 2'd0;
    localparam logic [1:0] RESP_OK   = 2'd1;
    localparam logic [1:0] RESP_ERR  = 2'd2;

    // The block runs only when every reset bit is high; any low bit resets it.
    logic rst_n;
    assign rst_n = &reset;

    // Gather the per-port pins into arrays so all ports share one generate body.
    logic [3:0]  cmd_in  [4];
    logic [31:0] data_in [4];
    logic [1:0]  tag_in  [4];
    logic [1:0]  resp_q  [4];
    logic [31:0] data_q  [4];
    logic [1:0]  tag_q   [4];

    assign cmd_in[0]  = req1_cmd_in;
    assign cmd_in[1]  = req2_cmd_in;
    assign cmd_in[2]  = req3_cmd_in;
    assign cmd_in[3]  = req4_cmd_in;
    assign data_in[0] = req1_data_in;
    assign data_in[1] = req2_data_in;
    assign data_in[2] = req3_data_in;
    assign data_in[3] = req4_data_in;
    assign tag_in[0]  = req1_tag_in;
    assign tag_in[1]  = req2_tag_in;
    assign tag_in[2]  = req3_tag_in;
    assign tag_in[3]  = req4_tag_in;

    assign out_resp1 = resp_q[0];
    assign out_data1 = data_q[0];
    assign out_tag1  = tag_q[0];
    assign out_resp2 = resp_q[1];
    assign out_data2 = data_q[1];
    assign out_tag2  = tag_q[1];
    assign out_resp3 = resp_q[2];
    assign out_data3 = data_q[2];
    assign out_tag3  = tag_q[2];
    assign out_resp4 = resp_q[3];
    assign out_data4 = data_q[3];
    assign out_tag4  = tag_q[3];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_port
            state_t      state_reg;
            state_t      state_next;
            logic        cap_cmd;
            logic        cap_op2;

            logic [3:0]  cmd_reg;
            logic [31:0] op1_reg;
            logic [31:0] op2_reg;
            logic [1:0]  tag_reg;

            logic [32:0] sum;
            logic [1:0]  resp_next;
            logic [31:0] data_next;

            logic [1:0]  resp_reg;
            logic [31:0] data_reg;
            logic [1:0]  tag_out_reg;

            // State register for the per-port capture sequencer.
            always_ff @(posedge c_clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_reg <= ST_IDLE;
                end else begin
                    state_reg <= state_next;
                end
            end

            // Next-state and capture strobes; the response edge doubles as a
            // command edge so back-to-back commands need no idle cycle.
            always_comb begin
                state_next = state_reg;
                cap_cmd    = 1'b0;
                cap_op2    = 1'b0;
                case (state_reg)
                    ST_IDLE: begin
                        if (cmd_in[gi] != CMD_NOP) begin
                            cap_cmd    = 1'b1;
                            state_next = ST_OPND;
                        end
                    end
                    ST_OPND: begin
                        // Whatever is on the command pins now is ignored.
                        cap_op2    = 1'b1;
                        state_next = ST_EXEC;
                    end
                    ST_EXEC: begin
                        if (cmd_in[gi] != CMD_NOP) begin
                            cap_cmd    = 1'b1;
                            state_next = ST_OPND;
                        end else begin
                            state_next = ST_IDLE;
                        end
                    end
                    default: begin
                        state_next = ST_IDLE;
                    end
                endcase
            end

            // Capture registers for command, operand1, tag and operand2.
            always_ff @(posedge c_clk or negedge rst_n) begin
                if (!rst_n) begin
                    cmd_reg <= CMD_NOP;
                    op1_reg <= '0;
                    op2_reg <= '0;
                    tag_reg <= '0;
                end else begin
                    if (cap_cmd) begin
                        cmd_reg <= cmd_in[gi];
                        op1_reg <= data_in[gi];
                        tag_reg <= tag_in[gi];
                    end
                    if (cap_op2) begin
                        op2_reg <= data_in[gi];
                    end
                end
            end

            // ALU: unsigned add/sub with range errors, logical shifts by the
            // low five bits of operand2, everything else is an invalid command.
            always_comb begin
                sum       = {1'b0, op1_reg} + {1'b0, op2_reg};
                resp_next = RESP_ERR;
                data_next = '0;
                case (cmd_reg)
                    CMD_ADD: begin
                        if (!sum[32]) begin
                            resp_next = RESP_OK;
                            data_next = sum[31:0];
                        end
                    end
                    CMD_SUB: begin
                        if (op1_reg >= op2_reg) begin
                            resp_next = RESP_OK;
                            data_next = op1_reg - op2_reg;
                        end
                    end
                    CMD_SHL: begin
                        resp_next = RESP_OK;
                        data_next = op1_reg << op2_reg[4:0];
                    end
                    CMD_SHR: begin
                        resp_next = RESP_OK;
                        data_next = op1_reg >> op2_reg[4:0];
                    end
                    default: begin
                        resp_next = RESP_ERR;
                        data_next = '0;
                    end
                endcase
            end

            // Response registers: loaded for exactly one cycle on the response
            // edge, otherwise forced to zero so idle outputs read all-zero.
            always_ff @(posedge c_clk or negedge rst_n) begin
                if (!rst_n) begin
                    resp_reg    <= RESP_NONE;
                    data_reg    <= '0;
                    tag_out_reg <= '0;
                end else if (state_reg == ST_EXEC) begin
                    resp_reg    <= resp_next;
                    data_reg    <= data_next;
                    tag_out_reg <= tag_reg;
                end else begin
                    resp_reg    <= RESP_NONE;
                    data_reg    <= '0;
                    tag_out_reg <= '0;
                end
            end

            assign resp_q[gi] = resp_reg;
            assign data_q[gi] = data_reg;
            assign tag_q[gi]  = tag_out_reg;
        end
    endgenerate

endmodule

// File: tb/tb_calc1_top.sv
// Directed testbench for calc1_top: one task per scenario, inline checks.
`timescale 1ns/1ps
module tb_calc1_top;

    logic        c_clk;
    logic [6:0]  reset;
    logic [3:0]  cmd  [4];
    logic [31:0] din  [4];
    logic [1:0]  tin  [4];
    logic [1:0]  resp [4];
    logic [31:0] dout [4];
    logic [1:0]  tout [4];

    int pass_cnt  = 0;
    int total_cnt = 0;

    calc1_top dut (
        .c_clk        (c_clk),
        .reset        (reset),
        .req1_cmd_in  (cmd[0]), .req1_data_in (din[0]), .req1_tag_in (tin[0]),
        .req2_cmd_in  (cmd[1]), .req2_data_in (din[1]), .req2_tag_in (tin[1]),
        .req3_cmd_in  (cmd[2]), .req3_data_in (din[2]), .req3_tag_in (tin[2]),
        .req4_cmd_in  (cmd[3]), .req4_data_in (din[3]), .req4_tag_in (tin[3]),
        .out_resp1    (resp[0]), .out_data1 (dout[0]), .out_tag1 (tout[0]),
        .out_resp2    (resp[1]), .out_data2 (dout[1]), .out_tag2 (tout[1]),
        .out_resp3    (resp[2]), .out_data3 (dout[2]), .out_tag3 (tout[2]),
        .out_resp4    (resp[3]), .out_data4 (dout[3]), .out_tag4 (tout[3])
    );

    initial c_clk = 1'b0;
    always #5 c_clk = ~c_clk;

    // Hard stop in case something stalls the sequence.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge c_clk);
        #1;
    endtask

    task automatic idle_inputs();
        for (int p = 0; p < 4; p++) begin
            cmd[p] = 4'd0;
            din[p] = 32'd0;
            tin[p] = 2'd0;
        end
    endtask

    task automatic test_reset();
        for (int p = 0; p < 4; p++) begin
            cmd[p] = 4'd1;
            din[p] = 32'hDEAD_0000 + p;
            tin[p] = 2'(p);
        end
        reset = 7'h00;
        for (int k = 0; k < 4; k++) step();
        for (int p = 0; p < 4; p++) begin
            total_cnt++;
            if ({resp[p], dout[p], tout[p]} !== 36'd0)
                $display("FAIL reset_hold port%0d: got resp=%0d data=%h tag=%0d, need all 0",
                         p + 1, resp[p], dout[p], tout[p]);
            else pass_cnt++;
        end
        // A single low bit still holds the block in reset.
        reset = 7'h7E;
        for (int k = 0; k < 3; k++) step();
        for (int p = 0; p < 4; p++) begin
            total_cnt++;
            if ({resp[p], dout[p], tout[p]} !== 36'd0)
                $display("FAIL reset_partial port%0d: got resp=%0d data=%h tag=%0d, need all 0",
                         p + 1, resp[p], dout[p], tout[p]);
            else pass_cnt++;
        end
        idle_inputs();
        reset = 7'h7F;
        step();
    endtask

    task automatic test_alu();
        logic [3:0]  c_t [9];
        logic [31:0] a_t [9];
        logic [31:0] b_t [9];
        logic [1:0]  r_t [9];
        logic [31:0] d_t [9];
        int p;
        c_t[0] = 4'd1; a_t[0] = 32'h30;        b_t[0] = 32'h20;        r_t[0] = 2'd1; d_t[0] = 32'h50;
        c_t[1] = 4'd1; a_t[1] = 32'hFFFFFFFF;  b_t[1] = 32'h1;         r_t[1] = 2'd2; d_t[1] = 32'h0;
        c_t[2] = 4'd2; a_t[2] = 32'h5;         b_t[2] = 32'h6;         r_t[2] = 2'd2; d_t[2] = 32'h0;
        c_t[3] = 4'd2; a_t[3] = 32'h6;         b_t[3] = 32'h6;         r_t[3] = 2'd1; d_t[3] = 32'h0;
        c_t[4] = 4'd5; a_t[4] = 32'h1;         b_t[4] = 32'd31;        r_t[4] = 2'd1; d_t[4] = 32'h80000000;
        c_t[5] = 4'd6; a_t[5] = 32'h80000000;  b_t[5] = 32'h21;        r_t[5] = 2'd1; d_t[5] = 32'h40000000;
        c_t[6] = 4'd1; a_t[6] = 32'h7FFFFFFF;  b_t[6] = 32'h80000000;  r_t[6] = 2'd1; d_t[6] = 32'hFFFFFFFF;
        c_t[7] = 4'd2; a_t[7] = 32'hFFFFFFFF;  b_t[7] = 32'h1;         r_t[7] = 2'd1; d_t[7] = 32'hFFFFFFFE;
        c_t[8] = 4'd5; a_t[8] = 32'hF0F0F0F0;  b_t[8] = 32'hFFFFFFE4;  r_t[8] = 2'd1; d_t[8] = 32'h0F0F0F00;
        for (int i = 0; i < 9; i++) begin
            p = (i == 0) ? 0 : i % 4;
            cmd[p] = c_t[i];
            din[p] = a_t[i];
            tin[p] = 2'(i);
            step();                       // E0
            din[p] = b_t[i];
            cmd[p] = 4'hF;                // must be ignored at E1
            tin[p] = ~2'(i);
            step();                       // E1
            total_cnt++;
            if ({resp[p], dout[p], tout[p]} !== 36'd0)
                $display("FAIL alu_early vec%0d: got resp=%0d data=%h, need 0 one edge after command",
                         i, resp[p], dout[p]);
            else pass_cnt++;
            idle_inputs();
            step();                       // E2
            total_cnt++;
            if ({resp[p], dout[p], tout[p]} !== {r_t[i], d_t[i], 2'(i)})
                $display("FAIL alu_result vec%0d: got resp=%0d data=%h tag=%0d, need resp=%0d data=%h tag=%0d",
                         i, resp[p], dout[p], tout[p], r_t[i], d_t[i], i % 4);
            else pass_cnt++;
            step();                       // E2+1
            total_cnt++;
            if ({resp[p], dout[p], tout[p]} !== 36'd0)
                $display("FAIL alu_hold vec%0d: got resp=%0d data=%h tag=%0d, need 0 after one cycle",
                         i, resp[p], dout[p], tout[p]);
            else pass_cnt++;
        end
    endtask

    task automatic test_invalid();
        logic [3:0] bad [4];
        cmd[1] = 4'd3; din[1] = 32'h1234; tin[1] = 2'd2;
        step();
        cmd[1] = 4'd0; din[1] = 32'h1;
        step();
        idle_inputs();
        step();
        total_cnt++;
        if ({resp[1], dout[1], tout[1]} !== {2'd2, 32'd0, 2'd2})
            $display("FAIL invalid_cmd3: got resp=%0d data=%h tag=%0d, need resp=2 data=0 tag=2",
                     resp[1], dout[1], tout[1]);
        else pass_cnt++;
        for (int p = 0; p < 4; p++) begin
            if (p != 1) begin
                total_cnt++;
                if ({resp[p], dout[p], tout[p]} !== 36'd0)
                    $display("FAIL invalid_isolation port%0d: got resp=%0d data=%h tag=%0d, need 0",
                             p + 1, resp[p], dout[p], tout[p]);
                else pass_cnt++;
            end
        end
        // Other undefined opcodes on all ports at once.
        bad[0] = 4'd4; bad[1] = 4'd7; bad[2] = 4'd11; bad[3] = 4'd15;
        for (int p = 0; p < 4; p++) begin
            cmd[p] = bad[p]; din[p] = 32'h10; tin[p] = 2'(3 - p);
        end
        step();
        for (int p = 0; p < 4; p++) begin
            cmd[p] = 4'd0; din[p] = 32'h1;
        end
        step();
        idle_inputs();
        step();
        for (int p = 0; p < 4; p++) begin
            total_cnt++;
            if ({resp[p], dout[p], tout[p]} !== {2'd2, 32'd0, 2'(3 - p)})
                $display("FAIL invalid_other port%0d: got resp=%0d data=%h tag=%0d, need resp=2 data=0 tag=%0d",
                         p + 1, resp[p], dout[p], tout[p], 3 - p);
            else pass_cnt++;
        end
        step();
    endtask

    task automatic test_parallel();
        logic [3:0]  c_t [4];
        logic [31:0] a_t [4];
        logic [31:0] b_t [4];
        logic [31:0] d_t [4];
        c_t[0] = 4'd1; a_t[0] = 32'd1;     b_t[0] = 32'd2;  d_t[0] = 32'd3;
        c_t[1] = 4'd2; a_t[1] = 32'd10;    b_t[1] = 32'd3;  d_t[1] = 32'd7;
        c_t[2] = 4'd5; a_t[2] = 32'd3;     b_t[2] = 32'd2;  d_t[2] = 32'hC;
        c_t[3] = 4'd6; a_t[3] = 32'h100;   b_t[3] = 32'd4;  d_t[3] = 32'h10;
        for (int p = 0; p < 4; p++) begin
            cmd[p] = c_t[p]; din[p] = a_t[p]; tin[p] = 2'(p);
        end
        step();
        for (int p = 0; p < 4; p++) begin
            cmd[p] = 4'd0; din[p] = b_t[p];
        end
        step();
        idle_inputs();
        step();
        for (int p = 0; p < 4; p++) begin
            total_cnt++;
            if ({resp[p], dout[p], tout[p]} !== {2'd1, d_t[p], 2'(p)})
                $display("FAIL parallel port%0d: got resp=%0d data=%h tag=%0d, need resp=1 data=%h tag=%0d",
                         p + 1, resp[p], dout[p], tout[p], d_t[p], p);
            else pass_cnt++;
        end
        step();
    endtask

    task automatic test_back_to_back();
        cmd[2] = 4'd1; din[2] = 32'h100; tin[2] = 2'd1;
        step();                           // E0 of A
        cmd[2] = 4'd0; din[2] = 32'h23;
        step();                           // E1 of A
        cmd[2] = 4'd2; din[2] = 32'h50; tin[2] = 2'd3;
        step();                           // E2 of A, E0 of B
        total_cnt++;
        if ({resp[2], dout[2], tout[2]} !== {2'd1, 32'h123, 2'd1})
            $display("FAIL b2b_first: got resp=%0d data=%h tag=%0d, need resp=1 data=123 tag=1",
                     resp[2], dout[2], tout[2]);
        else pass_cnt++;
        cmd[2] = 4'd0; din[2] = 32'h8;
        step();                           // E1 of B
        total_cnt++;
        if ({resp[2], dout[2], tout[2]} !== 36'd0)
            $display("FAIL b2b_gap: got resp=%0d data=%h tag=%0d, need 0",
                     resp[2], dout[2], tout[2]);
        else pass_cnt++;
        idle_inputs();
        step();                           // E2 of B
        total_cnt++;
        if ({resp[2], dout[2], tout[2]} !== {2'd1, 32'h48, 2'd3})
            $display("FAIL b2b_second: got resp=%0d data=%h tag=%0d, need resp=1 data=48 tag=3",
                     resp[2], dout[2], tout[2]);
        else pass_cnt++;
        step();
    endtask

    task automatic test_noop();
        for (int p = 0; p < 4; p++) begin
            cmd[p] = 4'd0; din[p] = 32'hFFFF0000; tin[p] = 2'd3;
        end
        for (int k = 0; k < 3; k++) begin
            step();
            for (int p = 0; p < 4; p++) begin
                total_cnt++;
                if ({resp[p], dout[p], tout[p]} !== 36'd0)
                    $display("FAIL noop cycle%0d port%0d: got resp=%0d data=%h tag=%0d, need 0",
                             k, p + 1, resp[p], dout[p], tout[p]);
                else pass_cnt++;
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_inflight();
        // Port 2 leads by one cycle so its response is visible when reset hits.
        cmd[1] = 4'd1; din[1] = 32'd2; tin[1] = 2'd3;
        step();
        cmd[1] = 4'd0; din[1] = 32'd3;
        cmd[0] = 4'd1; din[0] = 32'h30; tin[0] = 2'd1;
        step();
        cmd[0] = 4'd0; din[0] = 32'h20; din[1] = 32'd0;
        step();                           // port2 E2, port1 E1
        total_cnt++;
        if ({resp[1], dout[1], tout[1]} !== {2'd1, 32'd5, 2'd3})
            $display("FAIL rst_pre_resp: got resp=%0d data=%h tag=%0d, need resp=1 data=5 tag=3",
                     resp[1], dout[1], tout[1]);
        else pass_cnt++;
        #1;
        reset = 7'h5F;
        #1;
        total_cnt++;
        if ({resp[1], dout[1], tout[1]} !== 36'd0)
            $display("FAIL rst_async_clear: got resp=%0d data=%h tag=%0d, need 0 right after reset",
                     resp[1], dout[1], tout[1]);
        else pass_cnt++;
        step();
        step();
        idle_inputs();
        reset = 7'h7F;
        for (int k = 0; k < 3; k++) begin
            step();
            total_cnt++;
            if ({resp[0], dout[0], tout[0]} !== 36'd0)
                $display("FAIL rst_discard cycle%0d: got resp=%0d data=%h tag=%0d, need 0",
                         k, resp[0], dout[0], tout[0]);
            else pass_cnt++;
        end
        cmd[0] = 4'd1; din[0] = 32'h11; tin[0] = 2'd2;
        step();
        cmd[0] = 4'd0; din[0] = 32'h22;
        step();
        idle_inputs();
        step();
        total_cnt++;
        if ({resp[0], dout[0], tout[0]} !== {2'd1, 32'h33, 2'd2})
            $display("FAIL rst_recover: got resp=%0d data=%h tag=%0d, need resp=1 data=33 tag=2",
                     resp[0], dout[0], tout[0]);
        else pass_cnt++;
        step();
    endtask

    initial begin
        idle_inputs();
        reset = 7'h00;
        test_reset();
        test_alu();
        test_invalid();
        test_parallel();
        test_back_to_back();
        test_noop();
        test_reset_inflight();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
